// File: rtl/sel_scan_sched.sv
// Automatic scan sequencer for the calibration input multiplexer selector.
// For each channel in [CH_FIRST, CH_LAST]: select write (En=1), settle,
// one measurement request, release write (En=0), then wait for the
// selector's active flag to drop before moving on.
module sel_scan_sched #(
  parameter int MAX_CH     = 156,
  parameter int SETTLE_CYC = 64,
  parameter int TO_W       = 16
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        start,
  input  logic        abort,
  output logic        sel_req,
  output logic        sel_valid,
  output logic [31:0] sel_data,
  input  logic        sel_active,
  output logic        meas_strobe,
  input  logic        meas_done,
  output logic [7:0]  cur_ch,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic        err_cfg
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [7:0] MAX_CH_C = 8'(MAX_CH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEL    = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_MEAS   = 3'd3;
  localparam logic [2:0] ST_REL    = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;

  // Configuration registers
  logic [7:0]      ch_first_q, ch_first_d;
  logic [7:0]      ch_last_q, ch_last_d;
  logic [TO_W-1:0] timeout_q, timeout_d;
  logic            cont_q, cont_d;

  // Sequencer state
  logic [2:0]      state_q, state_d;
  logic [7:0]      cur_ch_q, cur_ch_d;
  logic [SW-1:0]   set_cnt_q, set_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            abort_q, abort_d;
  logic            drain_first_q, drain_first_d;
  logic            err_timeout_q, err_timeout_d;

  // Registered outputs
  logic            sel_req_q, sel_req_d;
  logic            sel_valid_q, sel_valid_d;
  logic [31:0]     sel_data_q, sel_data_d;
  logic            meas_strobe_q, meas_strobe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_cfg_q, err_cfg_d;

  logic            cfg_ok_s;
  logic            unused_cfg_s;

  assign cfg_ok_s     = (ch_first_q <= ch_last_q) && (ch_last_q <= MAX_CH_C);
  assign unused_cfg_s = ^cfg_wdata;

  // Config register writes, accepted only while the sequencer is idle
  always_comb begin
    ch_first_d = ch_first_q;
    ch_last_d  = ch_last_q;
    timeout_d  = timeout_q;
    cont_d     = cont_q;
    if (cfg_we && (state_q == ST_IDLE)) begin
      case (cfg_addr)
        2'd0: begin
          ch_first_d = cfg_wdata[7:0];
          ch_last_d  = cfg_wdata[15:8];
        end
        2'd1: timeout_d = cfg_wdata[TO_W-1:0];
        2'd2: cont_d    = cfg_wdata[0];
        default: cont_d = cont_q;
      endcase
    end else begin
      cont_d = cont_q;
    end
  end

  // Scan sequencer next-state logic
  always_comb begin
    state_d       = state_q;
    cur_ch_d      = cur_ch_q;
    set_cnt_d     = set_cnt_q;
    to_cnt_d      = to_cnt_q;
    abort_d       = abort_q;
    drain_first_d = drain_first_q;
    err_timeout_d = err_timeout_q;
    done_d        = 1'b0;
    err_cfg_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          if (cfg_ok_s) begin
            cur_ch_d      = ch_first_q;
            err_timeout_d = 1'b0;
            state_d       = ST_SEL;
          end else begin
            err_cfg_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEL: begin
        // The select write always completes; an abort diverts straight to release
        if (abort || abort_q) begin
          abort_d = 1'b1;
          state_d = ST_REL;
        end else begin
          set_cnt_d = SW'(SETTLE_CYC - 1);
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          abort_d = 1'b1;
          state_d = ST_REL;
        end else if (set_cnt_q == {SW{1'b0}}) begin
          to_cnt_d = timeout_q;
          state_d  = ST_MEAS;
        end else begin
          set_cnt_d = set_cnt_q - SW'(1);
        end
      end
      ST_MEAS: begin
        // Abort wins over a same-cycle meas_done
        if (abort) begin
          abort_d = 1'b1;
          state_d = ST_REL;
        end else if (meas_done) begin
          state_d = ST_REL;
        end else if (to_cnt_q == {TO_W{1'b0}}) begin
          err_timeout_d = 1'b1;
          state_d       = ST_REL;
        end else begin
          to_cnt_d = to_cnt_q - TO_W'(1);
        end
      end
      ST_REL: begin
        if (abort) begin
          abort_d = 1'b1;
        end else begin
          abort_d = abort_q;
        end
        to_cnt_d      = timeout_q;
        drain_first_d = 1'b1;
        state_d       = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_first_d = 1'b0;
        if (abort) begin
          abort_d = 1'b1;
        end else begin
          abort_d = abort_q;
        end
        // sel_active may still reflect the select write on the first cycle
        if (!drain_first_q && !sel_active) begin
          if (abort || abort_q) begin
            state_d = ST_IDLE;
          end else if (cur_ch_q < ch_last_q) begin
            cur_ch_d = cur_ch_q + 8'd1;
            state_d  = ST_SEL;
          end else if (cont_q) begin
            cur_ch_d = ch_first_q;
            state_d  = ST_SEL;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (to_cnt_q == {TO_W{1'b0}}) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q - TO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    sel_req_d     = (state_d == ST_SEL) || (state_d == ST_REL);
    sel_valid_d   = sel_req_d;
    meas_strobe_d = (state_d == ST_MEAS) && (state_q != ST_MEAS);
    busy_d        = (state_d != ST_IDLE);
    if (sel_req_d) begin
      sel_data_d = {23'd0, (state_d == ST_SEL), cur_ch_d};
    end else begin
      sel_data_d = 32'd0;
    end
  end

  // Config register flops
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ch_first_q <= 8'd0;
      ch_last_q  <= 8'd0;
      timeout_q  <= {TO_W{1'b1}};
      cont_q     <= 1'b0;
    end else begin
      ch_first_q <= ch_first_d;
      ch_last_q  <= ch_last_d;
      timeout_q  <= timeout_d;
      cont_q     <= cont_d;
    end
  end

  // Sequencer state flops
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q       <= ST_IDLE;
      cur_ch_q      <= 8'd0;
      set_cnt_q     <= {SW{1'b0}};
      to_cnt_q      <= {TO_W{1'b0}};
      abort_q       <= 1'b0;
      drain_first_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_ch_q      <= cur_ch_d;
      set_cnt_q     <= set_cnt_d;
      to_cnt_q      <= to_cnt_d;
      abort_q       <= abort_d;
      drain_first_q <= drain_first_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Output flops
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sel_req_q     <= 1'b0;
      sel_valid_q   <= 1'b0;
      sel_data_q    <= 32'd0;
      meas_strobe_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_cfg_q     <= 1'b0;
    end else begin
      sel_req_q     <= sel_req_d;
      sel_valid_q   <= sel_valid_d;
      sel_data_q    <= sel_data_d;
      meas_strobe_q <= meas_strobe_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_cfg_q     <= err_cfg_d;
    end
  end

  assign sel_req     = sel_req_q;
  assign sel_valid   = sel_valid_q;
  assign sel_data    = sel_data_q;
  assign meas_strobe = meas_strobe_q;
  assign cur_ch      = cur_ch_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_timeout_q;
  assign err_cfg     = err_cfg_q;

endmodule

// File: doc/sel_scan_sched.md
Name: sel_scan_sched

Overview:
- Automatic scan sequencer for the calibration input multiplexer selector.
- Steps through a programmed channel range. For each channel it:
  - issues a select write with En=1 on the selector's PCI-style write port;
  - waits a settle time;
  - requests one measurement;
  - releases the channel with an En=0 write;
  - waits for the selector's active flag to drop before advancing.
- Sits between the PCI register space and the selector. It replaces manual per-channel PCI writes during calibration.

Parameters:
- MAX_CH, 156: highest legal channel index; ROM depth minus 1.
- SETTLE_CYC, 64: clk cycles from the select write to the measurement request. Covers the selector pause and its two-stage address/enable latch.
- TO_W, 16: width of the timeout counter and the TIMEOUT register.

Ports:
- clk  in  1  system clock
- rst_  in  1  asynchronous active-low reset
- cfg_we  in  1  config write strobe; one cycle per write
- cfg_addr  in  2  config register select
- cfg_wdata  in  32  config write data
- start  in  1  one-cycle pulse; begins a scan
- abort  in  1  one-cycle pulse; stops the scan safely
- sel_req  out  1  selector chip-select; drives data_in_1_sel
- sel_valid  out  1  selector write strobe; drives valid_pci
- sel_data  out  32  selector write word: bits [7:0]=CH, bit [8]=En, all other bits 0
- sel_active  in  1  selector busy flag (data_in_1_sel_active)
- meas_strobe  out  1  one-cycle measurement request
- meas_done  in  1  measurement complete pulse
- cur_ch  out  8  channel currently selected
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a single-pass scan
- err_timeout  out  1  sticky; cleared only by an accepted start
- err_cfg  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Config registers reset to CH_FIRST=0, CH_LAST=0, TIMEOUT=16'hFFFF, CONT=0.
- Config registers:
  - addr 0: CH_FIRST = wdata[7:0], CH_LAST = wdata[15:8].
  - addr 1: TIMEOUT = wdata[TO_W-1:0].
  - addr 2: CONT = wdata[0].
  - addr 3: reserved; writes are ignored.
  - cfg_we is ignored while busy=1.
- start in IDLE:
  - Accepted only if CH_FIRST <= CH_LAST <= MAX_CH. On accept: cur_ch <= CH_FIRST, err_timeout cleared, go to SEL.
  - Otherwise err_cfg pulses and the FSM stays in IDLE.
  - start is ignored when busy=1.
- SEL (1 cycle):
  - sel_req=1 and sel_valid=1 together.
  - sel_data = {23'b0, 1'b1, cur_ch}.
  - Go to SETTLE with the counter loaded to SETTLE_CYC-1.
- SETTLE: counter decrements each cycle; at 0 go to MEAS.
  - The select write occurs at cycle t; meas_strobe asserts at t+SETTLE_CYC+1.
- MEAS:
  - meas_strobe is high only on the first cycle of MEAS.
  - Wait for meas_done. A meas_done arriving on the strobe cycle is accepted.
  - Timeout counter loads TIMEOUT on entry. On expiry: set err_timeout, go to REL.
- REL (1 cycle):
  - sel_req=1 and sel_valid=1, sel_data = {23'b0, 1'b0, cur_ch}.
  - Go to DRAIN with the timeout counter reloaded.
- DRAIN: wait for sel_active=0, sampled from the second DRAIN cycle onward.
  - On timeout: set err_timeout and go to IDLE, no advance.
  - On sel_active=0:
    - cur_ch < CH_LAST: cur_ch+1, go to SEL.
    - cur_ch == CH_LAST and CONT=1: cur_ch <= CH_FIRST, go to SEL.
    - cur_ch == CH_LAST and CONT=0: pulse done, go to IDLE.
- abort:
  - In SETTLE or MEAS: go to REL next cycle. The measurement is dropped and no further meas_strobe is issued.
  - In SEL: complete the write, then go to REL.
  - In REL or DRAIN: latch the abort; on DRAIN exit go to IDLE without advancing and without done.
  - In IDLE: ignored.
  - An abort takes priority over a same-cycle meas_done.
- Outside SEL and REL, sel_req and sel_valid are 0. Every selector write is exactly one cycle with both strobes high.
- Timeout counter is TO_W bits. TIMEOUT=0 means expiry on the first wait cycle.
- cur_ch holds its value in IDLE after a scan.
- An asynchronous reset mid-scan returns everything to reset values. No release write is issued; the selector's own reset clears its outputs.

Test Plan:
- CH_FIRST=3, CH_LAST=5, CONT=0, SETTLE_CYC=64, selector model drops sel_active 10 cycles after an En=0 write, meas_done 5 cycles after the strobe -> writes for CH 3,4,5 with En=1 then En=0 each; sel_data 0x103 then 0x003 for CH 3; meas_strobe exactly 65 cycles after each En=1 write; done pulses once; busy falls with done.
- CH_FIRST=10, CH_LAST=9, start -> err_cfg one-cycle pulse, busy stays 0, no selector writes.
- TIMEOUT=20, meas_done never arrives -> err_timeout sets 20 cycles into MEAS, En=0 write follows, scan continues; err_timeout stays high until the next accepted start.
- CONT=1, CH 0..1 -> channel order 0,1,0,1...; abort during MEAS of CH 1 -> En=0 write for CH 1, no further meas_strobe, IDLE with cur_ch=1, no done.
- sel_active held high forever -> DRAIN timeout, err_timeout=1, IDLE, cur_ch not advanced.
- rst_ driven low asynchronously mid-SETTLE (not clock-aligned) -> all outputs 0 immediately, config registers at reset values.
